// File: rtl/dcache_tag_ctrl.sv
// dcache_tag_ctrl: sequencer for the data-cache tag store.
// It clears the 512-entry tag RAM after reset. It then serialises load
// lookups, store lookups, fills and invalidates from the cache pipeline.
// Optional feature macro: DCACHE_TAG_STATS_EN builds the hit/miss counters.
// Without the macro, hit_cnt and miss_cnt are tied to 0.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and never while
// rst is asserted. resp_valid is a single-cycle pulse with no back-pressure.
module dcache_tag_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 9,
  parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic                   req_fill_dirty,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic                   resp_dirty,
  output logic                   resp_victim_valid,
  output logic                   resp_victim_dirty,
  output logic [TAG_WIDTH-1:0]   resp_victim_tag,
  output logic                   init_done,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt,
  output logic                   tag_wr_en,
  output logic [INDEX_WIDTH-1:0] tag_wr_addr,
  output logic [TAG_WIDTH+1:0]   tag_wr_data,
  output logic [INDEX_WIDTH-1:0] tag_rd_addr,
  input  logic [TAG_WIDTH+1:0]   tag_rd_data
);

  localparam int EW = TAG_WIDTH + 2;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_LOOKUP = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] sweep_cnt;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-1:0]   tag_q;
  logic                   op_store_q;

  logic [INDEX_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic                   rd_valid, rd_dirty, lookup_hit;
  logic [TAG_WIDTH-1:0]   rd_tag;
  logic                   unused_offset;

  assign req_idx       = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_tag       = req_addr[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];
  assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

  assign rd_valid   = tag_rd_data[EW-1];
  assign rd_dirty   = tag_rd_data[EW-2];
  assign rd_tag     = tag_rd_data[TAG_WIDTH-1:0];
  assign lookup_hit = rd_valid && (rd_tag == tag_q);

  // Next-state, handshake and tag RAM port control; rst forces quiet ports.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    tag_wr_en   = 1'b0;
    tag_wr_addr = sweep_cnt;
    tag_wr_data = '0;
    tag_rd_addr = idx_q;
    case (state)
      S_INIT: begin
        tag_wr_en   = 1'b1;
        tag_wr_addr = sweep_cnt;
        if (sweep_cnt == '1) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        req_ready   = 1'b1;
        tag_rd_addr = req_idx;
        if (req_valid) begin
          case (req_op)
            2'b10: begin
              tag_wr_en   = 1'b1;
              tag_wr_addr = req_idx;
              tag_wr_data = {1'b1, req_fill_dirty, req_tag};
            end
            2'b11: begin
              tag_wr_en   = 1'b1;
              tag_wr_addr = req_idx;
              tag_wr_data = '0;
            end
            default: state_nxt = S_LOOKUP;
          endcase
        end
      end
      S_LOOKUP: begin
        state_nxt = S_IDLE;
        // Only a store hit on a clean line needs the dirty bit set.
        if (op_store_q && lookup_hit && !rd_dirty) begin
          tag_wr_en   = 1'b1;
          tag_wr_addr = idx_q;
          tag_wr_data = {1'b1, 1'b1, tag_q};
        end
      end
      default: state_nxt = S_INIT;
    endcase
    if (rst) begin
      state_nxt   = S_INIT;
      req_ready   = 1'b0;
      tag_wr_en   = 1'b0;
      tag_rd_addr = '0;
    end
  end

  // State register, sweep counter and captured lookup request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_INIT;
      sweep_cnt  <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      op_store_q <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_cnt == '1) init_done <= 1'b1;
      end
      if (state == S_IDLE && req_valid && !req_op[1]) begin
        idx_q      <= req_idx;
        tag_q      <= req_tag;
        op_store_q <= req_op[0];
      end
    end
  end

  // Registered lookup response; fields hold their last value between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid        <= 1'b0;
      resp_hit          <= 1'b0;
      resp_dirty        <= 1'b0;
      resp_victim_valid <= 1'b0;
      resp_victim_dirty <= 1'b0;
      resp_victim_tag   <= '0;
    end else begin
      resp_valid <= (state == S_LOOKUP);
      if (state == S_LOOKUP) begin
        resp_hit          <= lookup_hit;
        resp_dirty        <= lookup_hit && (op_store_q || rd_dirty);
        resp_victim_valid <= !lookup_hit && rd_valid;
        resp_victim_dirty <= !lookup_hit && rd_valid && rd_dirty;
        resp_victim_tag   <= lookup_hit ? '0 : rd_tag;
      end
    end
  end

`ifdef DCACHE_TAG_STATS_EN
  logic [31:0] hit_q, miss_q;

  // Saturating hit/miss counters, updated alongside the response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == S_LOOKUP) begin
      if (lookup_hit) begin
        if (hit_q != '1) hit_q <= hit_q + 32'd1;
      end else begin
        if (miss_q != '1) miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// tb_dcache_tag_ctrl: directed bench for dcache_tag_ctrl with a behavioural
// 512 x 21 tag RAM (1-cycle read latency) attached to the RAM ports.
module tb_dcache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic        req_fill_dirty;
  logic        resp_valid, resp_hit, resp_dirty;
  logic        resp_victim_valid, resp_victim_dirty;
  logic [18:0] resp_victim_tag;
  logic        init_done;
  logic [31:0] hit_cnt, miss_cnt;
  logic        tag_wr_en;
  logic [8:0]  tag_wr_addr;
  logic [20:0] tag_wr_data;
  logic [8:0]  tag_rd_addr;
  logic [20:0] tag_rd_data;

  logic [20:0] mem [512];

  int n_tests = 0;
  int n_fail  = 0;

`ifdef DCACHE_TAG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  dcache_tag_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_addr          (req_addr),
    .req_fill_dirty    (req_fill_dirty),
    .resp_valid        (resp_valid),
    .resp_hit          (resp_hit),
    .resp_dirty        (resp_dirty),
    .resp_victim_valid (resp_victim_valid),
    .resp_victim_dirty (resp_victim_dirty),
    .resp_victim_tag   (resp_victim_tag),
    .init_done         (init_done),
    .hit_cnt           (hit_cnt),
    .miss_cnt          (miss_cnt),
    .tag_wr_en         (tag_wr_en),
    .tag_wr_addr       (tag_wr_addr),
    .tag_wr_data       (tag_wr_data),
    .tag_rd_addr       (tag_rd_addr),
    .tag_rd_data       (tag_rd_data)
  );

  // Clock.
  always #5 clk = ~clk;

  // Tag RAM model: registered read, read-before-write on the same edge.
  always @(posedge clk) begin
    if (tag_wr_en) mem[tag_wr_addr] <= tag_wr_data;
    tag_rd_data <= mem[tag_rd_addr];
  end

  // Safety net in case a wait escapes its bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Follows the clear sweep from the current negedge until req_ready rises.
  task automatic wait_init(input string name);
    int writes = 0;
    int bad    = 0;
    int first  = 0;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      #1;
      if (tag_wr_en) begin
        if (tag_wr_addr !== writes[8:0] || tag_wr_data !== 21'd0) bad++;
        writes++;
      end
      if (req_ready) begin
        first = cyc;
        break;
      end
      @(negedge clk);
    end
    check_eq({name, "_writes"}, writes, 512);
    check_eq({name, "_bad_writes"}, bad, 0);
    check_eq({name, "_first_ready_cycle"}, first, 513);
    check_eq({name, "_init_done"}, init_done, 1);
  endtask

  // Drives one request from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [1:0] op, input logic [31:0] addr, input logic fd);
    int n = 0;
    req_valid      = 1'b1;
    req_op         = op;
    req_addr       = addr;
    req_fill_dirty = fd;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) check_eq("send_ready_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
  endtask

  // Lookup accepted at T: quiet at T+1, response and ready at T+2.
  task automatic lookup(input string name, input logic [1:0] op, input logic [31:0] addr,
                        input logic hit, input logic dirty, input logic vv,
                        input logic vd, input logic [18:0] vtag);
    send(op, addr, 1'b0);
    check_eq({name, "_rv_t1"}, resp_valid, 0);
    check_eq({name, "_ready_t1"}, req_ready, 0);
    @(negedge clk);
    #1;
    check_eq({name, "_rv_t2"}, resp_valid, 1);
    check_eq({name, "_ready_t2"}, req_ready, 1);
    check_eq({name, "_hit"}, resp_hit, hit);
    check_eq({name, "_dirty"}, resp_dirty, dirty);
    check_eq({name, "_vvalid"}, resp_victim_valid, vv);
    check_eq({name, "_vdirty"}, resp_victim_dirty, vd);
    check_eq({name, "_vtag"}, resp_victim_tag, vtag);
  endtask

  initial begin
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_op         = 2'b00;
    req_addr       = '0;
    req_fill_dirty = 1'b0;
    // Garbage with valid set everywhere, so only the sweep can clear it.
    for (int i = 0; i < 512; i++) mem[i] = {1'b1, 1'b1, 19'($urandom_range(0, 19'h7FFFF))};

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_tag_wr_en", tag_wr_en, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_hit", resp_hit, 0);
    check_eq("rst_tag_rd_addr", tag_rd_addr, 0);
    check_eq("rst_hit_cnt", hit_cnt, 0);
    check_eq("rst_miss_cnt", miss_cnt, 0);

    rst = 1'b0;
    wait_init("init");

    // Cold lookup after the sweep: miss on an invalid entry.
    lookup("ld_cold", 2'b00, 32'h0000_1230, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
    // Clean fill, then a lookup the very next cycle at another offset.
    send(2'b10, 32'h0000_1230, 1'b0);
    check_eq("fill_mem", mem[9'h123], 32'h100000);
    lookup("ld_fill", 2'b00, 32'h0000_1238, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
    // Store hit marks the line dirty in the RAM.
    lookup("st_hit", 2'b01, 32'h0000_1230, 1'b1, 1'b1, 1'b0, 1'b0, 19'h0);
    check_eq("st_hit_mem", mem[9'h123], 32'h180000);
    lookup("ld_dirty", 2'b00, 32'h0000_1230, 1'b1, 1'b1, 1'b0, 1'b0, 19'h0);
    // Conflicting tag 0x40000 misses against the dirty resident line.
    lookup("ld_conflict", 2'b00, 32'h8000_1230, 1'b0, 1'b0, 1'b1, 1'b1, 19'h0);
    check_eq("conflict_mem_kept", mem[9'h123], 32'h180000);
    // Invalidate, then miss with no valid victim.
    send(2'b11, 32'h0000_1230, 1'b0);
    check_eq("inval_mem", mem[9'h123], 32'h0);
    lookup("ld_inval", 2'b00, 32'h0000_1230, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
    check_eq("ph1_hit_cnt", hit_cnt, STATS ? 32'd3 : 32'd0);
    check_eq("ph1_miss_cnt", miss_cnt, STATS ? 32'd3 : 32'd0);

    // Reset during T+1 of a lookup drops the response and restarts the sweep.
    send(2'b00, 32'h0000_1230, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_eq("midrst_resp_valid", resp_valid, 0);
    check_eq("midrst_req_ready", req_ready, 0);
    check_eq("midrst_init_done", init_done, 0);
    check_eq("midrst_hit_cnt", hit_cnt, 0);
    check_eq("midrst_miss_cnt", miss_cnt, 0);
    rst = 1'b0;
    wait_init("reinit");

    // Three hits and two misses after the restart.
    send(2'b10, 32'h0000_1230, 1'b0);
    lookup("p2_ld_hit0", 2'b00, 32'h0000_1230, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
    lookup("p2_ld_hit1", 2'b00, 32'h0000_123C, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
    lookup("p2_ld_hit2", 2'b00, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b0, 19'h0);
    lookup("p2_ld_miss0", 2'b00, 32'h0000_2470, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
    lookup("p2_ld_miss1", 2'b00, 32'h0000_2470, 1'b0, 1'b0, 1'b0, 1'b0, 19'h0);
    check_eq("p2_hit_cnt", hit_cnt, STATS ? 32'd3 : 32'd0);
    check_eq("p2_miss_cnt", miss_cnt, STATS ? 32'd2 : 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_tag_ctrl.md
# dcache_tag_ctrl

Sequencer for the data-cache tag store (512 × 21-bit simple dual-port RAM, 1-cycle read latency, no output register). It clears the store after reset and serialises four operations from the cache pipeline: load lookup, store lookup, fill and invalidate. It computes hit/miss, reports victim state, and sets the dirty bit on store hits. It sits between the LSU/refill logic and the tag RAM; both RAM ports are clocked by `clk`.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `OFFSET_WIDTH`, 4: line offset bits (16-byte lines).
- `INDEX_WIDTH`, 9: set index bits (512 sets).
- `TAG_WIDTH`, `ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH` (19): tag bits. Entry width is `TAG_WIDTH+2` (21). Layout: [20] valid, [19] dirty, [18:0] tag.
- `clk` in 1: single clock for the block and both tag RAM ports.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_op` in 2: 00 load lookup, 01 store lookup, 10 fill, 11 invalidate.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_fill_dirty` in 1: dirty bit written by a fill.
- `resp_valid` out 1: one-cycle pulse for lookups only.
- `resp_hit` out 1: lookup hit.
- `resp_dirty` out 1: line dirty after the operation (hit only).
- `resp_victim_valid`, `resp_victim_dirty` out 1 each; `resp_victim_tag` out TAG_WIDTH: resident entry on a miss.
- `init_done` out 1: high once the clear sweep has completed.
- `hit_cnt`, `miss_cnt` out 32: statistics (see Configuration).
- `tag_wr_en` out 1; `tag_wr_addr` out INDEX_WIDTH; `tag_wr_data` out TAG_WIDTH+2: tag RAM write port.
- `tag_rd_addr` out INDEX_WIDTH; `tag_rd_data` in TAG_WIDTH+2: tag RAM read port.

## Operation
- FSM states: INIT, IDLE, LOOKUP.
- INIT (entered on reset): a 9-bit sweep counter starts at 0. Each cycle writes `tag_wr_addr`=counter, `tag_wr_data`=0, `tag_wr_en`=1. After index 511 the FSM goes to IDLE and `init_done`=1. `req_ready`=0 throughout INIT.
- IDLE: `req_ready`=1. `tag_rd_addr` = `req_addr` index, combinationally, in IDLE; otherwise it holds the registered index.
  - Fill accepted: write `{1, req_fill_dirty, tag}` in the same cycle. FSM stays in IDLE. No response.
  - Invalidate accepted: write 0 in the same cycle. FSM stays in IDLE. No response.
  - Load or store accepted: register the index, tag and op, then go to LOOKUP.
- LOOKUP: `req_ready`=0. Hit = `tag_rd_data[20]` & (`tag_rd_data[18:0]` == registered tag).
  - Store hit on a clean line: write `{1,1,tag}` this cycle, and `resp_dirty`=1.
  - Load hit: `resp_dirty` = stored dirty bit.
  - Miss: `resp_victim_*` = stored valid, valid&dirty, tag. A miss does not modify the RAM.
  - Response fields are registered. Next state is IDLE.
- Reset values: `req_ready`=0, `resp_*`=0, `init_done`=0, `tag_wr_en`=0, `tag_rd_addr`=0, counters=0, state=INIT.
- `rst` asserted mid-operation or mid-sweep: the next state is INIT and the sweep restarts from 0. A pending lookup is dropped with no `resp_valid`.

## Timing
- Lookup accepted at cycle T: RAM read data is compared at T+1, `resp_valid` pulses at T+2, and `req_ready`=1 again at T+2. Throughput is one lookup per 2 cycles.
- The store-hit dirty write commits at the end of T+1, so a lookup accepted at T+2 sees the updated entry.
- Fill or invalidate accepted at T: write commits at the end of T. A lookup to the same index accepted at T+1 sees the new entry.
- Sweep duration: 512 cycles after reset deasserts. The first `req_ready`=1 is in cycle 513.

## Configuration
- `DCACHE_TAG_STATS_EN` defined: `hit_cnt` and `miss_cnt` increment by 1 in the cycle `resp_valid` pulses (hit or miss respectively). Both saturate at 0xFFFFFFFF and clear on `rst`.
- `DCACHE_TAG_STATS_EN` undefined: the counters are not built and `hit_cnt`/`miss_cnt` are tied to 0. Ports remain present.

## Test plan
- Reset released -> exactly 512 writes, addresses 0..511, data 0. `init_done` and `req_ready` go to 1 in cycle 513.
- Load 0x0000_1230 after init -> `resp_valid` at T+2, `resp_hit`=0, `resp_victim_valid`=0.
- Fill 0x0000_1230 with `req_fill_dirty`=0, then load 0x0000_1238 -> hit, `resp_dirty`=0. Store to 0x0000_1230 -> hit; RAM index 0x123 = 0x180000. A following load reports `resp_dirty`=1.
- Load 0x8000_1230 with a dirty resident entry at index 0x123 -> miss, `resp_victim_dirty`=1, `resp_victim_tag`=0x00000.
- Invalidate 0x0000_1230, then load 0x0000_1230 -> miss, `resp_victim_valid`=0.
- `rst` pulsed at T+1 of a lookup -> no `resp_valid`, the sweep restarts at index 0, and `hit_cnt`/`miss_cnt` return to 0 (with STATS). After 3 hits and 2 misses: `hit_cnt`=3, `miss_cnt`=2.
